// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned ILEN       = 32;
  localparam int unsigned FETCH_XLEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0]       inst;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer; pointers carry a wrap bit so full and empty are distinguishable.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ILEN + FETCH_XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW:0]      head_q, tail_q;
  logic [AW:0]      ptr_diff;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + (AW+1)'(1);
      if (pop)  head_q <= head_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; entries are only visible between head and tail.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q[AW-1:0]] <= wdata;
  end

  assign ptr_diff = tail_q - head_q;
  assign count    = CW'(ptr_diff);
  assign empty    = (head_q == tail_q);
  assign rdata    = mem_q[head_q[AW-1:0]];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch with credit-limited requests, in-order response queue and redirect.
// Define FETCH_BYPASS_EN to forward a kept response straight to decode when the queue is empty.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [ILEN-1:0]            imem_resp_data,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [ILEN-1:0]            inst,
  output logic [XLEN-1:0]            inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = ILEN + XLEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [XLEN-1:0] restart_pc;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW:0]     credit_used;
  logic            req_fire, keep;
  logic            q_push, q_pop, q_empty;
  logic [EW-1:0]   q_wdata, q_rdata;
  logic [ILEN-1:0] head_inst;
  logic [XLEN-1:0] head_pc;

  assign restart_pc = redirect_pc & ~XLEN'(3);
  assign q_wdata    = {imem_resp_data, resp_pc_q};
  assign {head_inst, head_pc} = q_rdata;

  // Credits use registered counts only, so a pop frees a slot one cycle later.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, occupancy};
  assign imem_req_valid = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign keep           = imem_resp_valid && !redirect && (drop_q == '0);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = keep && q_empty;
  assign inst_valid = !redirect && (!q_empty || bypass);
  assign inst       = bypass ? imem_resp_data : head_inst;
  assign inst_pc    = bypass ? resp_pc_q : head_pc;
  assign q_push     = keep && !(bypass && inst_ready);
  assign q_pop      = !redirect && !q_empty && inst_ready;
`else
  assign inst_valid = !redirect && !q_empty;
  assign inst       = q_empty ? NOP : head_inst;
  assign inst_pc    = head_pc;
  assign q_push     = keep;
  assign q_pop      = inst_valid && inst_ready;
`endif

  fetch_queue #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (occupancy),
    .empty (q_empty)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    if (redirect) begin
      fetch_pc_d = restart_pc;
      resp_pc_d  = restart_pc;
      // A response landing in the redirect cycle is wrong-path too, so it is not counted.
      drop_d     = outstanding_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (keep)     resp_pc_d  = resp_pc_q + XLEN'(4);
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with an in-order memory model and reference queue.
module tb_instruction_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid, inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [CW-1:0]   occupancy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1, ready_pct = 100, last_due = 0;

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] addr; bit stale;} out_t;
  typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
  pend_t mem_q[$];

  always #5 clk = ~clk;

  instruction_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .occupancy       (occupancy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory: drives 1 ns after each rising edge, books requests/responses on the falling edge.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_req_ready = ($urandom_range(99) < ready_pct);
      if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_q[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  end

  always @(negedge clk) begin : mem_book
    int d;
    if (reset) begin
      mem_q.delete();
      last_due = 0;
    end else begin
      if (imem_resp_valid && mem_q.size() > 0) mem_q.delete(0);
      if (imem_req_valid && imem_req_ready) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mem_q.push_back('{imem_req_addr, d});
      end
    end
  end

  task automatic do_reset(input bit rdy);
    @(posedge clk); #2;
    reset = 1'b1; redirect = 1'b0; inst_ready = rdy;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
    end
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid);
    end
    vectors++;
    if (occupancy !== CW'(0)) begin
      miscompares++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL first_request: got valid=%b addr=%h expected 1/00000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc, exp_req;
    int gaps, n;
    exp_pc = 0; exp_req = 0; gaps = 0; n = 0;
    lat_min = 2; lat_max = 2; ready_pct = 100;
    do_reset(1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        vectors++;
        if (imem_req_addr !== exp_req) begin
          miscompares++; $display("FAIL stream_req_addr: got %h expected %h", imem_req_addr, exp_req);
        end
        exp_req += 4;
      end
      if (inst_valid && inst_ready) begin
        vectors++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          miscompares++;
          $display("FAIL stream_inst: got pc=%h inst=%h expected pc=%h inst=%h",
                   inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4; n++;
      end
      if (i >= 10 && !inst_valid) gaps++;
    end
    vectors++;
    if (gaps != 0 || n < 30) begin
      miscompares++; $display("FAIL stream_gaps: got gaps=%0d delivered=%0d expected 0/>=30", gaps, n);
    end
  endtask

  task automatic test_stall();
    int fires;
    fires = 0;
    lat_min = 2; lat_max = 2; ready_pct = 100;
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
    end
    vectors++;
    if (fires != DEPTH) begin
      miscompares++; $display("FAIL stall_requests: got %0d expected %0d", fires, DEPTH);
    end
    vectors++;
    if (imem_req_valid !== 1'b0 || occupancy !== CW'(DEPTH)) begin
      miscompares++;
      $display("FAIL stall_full: got req_valid=%b occ=%0d expected 0/%0d", imem_req_valid, occupancy, DEPTH);
    end
    @(posedge clk); #2; inst_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_pop_cycle: got inst_valid=%b req_valid=%b expected 1/0", inst_valid, imem_req_valid);
    end
    @(posedge clk); #2; inst_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b1 || occupancy !== CW'(DEPTH - 1)) begin
      miscompares++;
      $display("FAIL stall_credit_back: got req_valid=%b occ=%0d expected 1/%0d",
               imem_req_valid, occupancy, DEPTH - 1);
    end
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall_one_per_pop: got req_valid=%b expected 0", imem_req_valid);
    end
  endtask

  task automatic test_redirect_inflight();
    int fires;
    bit found;
    fires = 0; found = 0;
    lat_min = 6; lat_max = 6; ready_pct = 100;
    do_reset(1'b1);
    for (int i = 0; i < 10 && fires < 3; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
      if (fires < 3) begin @(posedge clk); #2; end
    end
    @(posedge clk); #2;
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_cycle: got req_valid=%b inst_valid=%b expected 0/0", imem_req_valid, inst_valid);
    end
    @(posedge clk); #2; redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (occupancy !== CW'(0) || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL redir_restart: got occ=%0d req_valid=%b addr=%h expected 0/1/00000100",
               occupancy, imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 30 && !found; i++) begin
      if (i > 0) @(negedge clk);
      if (inst_valid) found = 1;
    end
    vectors++;
    if (!found || inst_pc !== 32'h100 || inst !== mem_word(32'h100)) begin
      miscompares++;
      $display("FAIL redir_first_inst: got found=%b pc=%h inst=%h expected 1/00000100/%h",
               found, inst_pc, inst, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_with_resp();
    bit found;
    found = 0;
    lat_min = 2; lat_max = 2; ready_pct = 100;
    do_reset(1'b1);
    repeat (6) @(posedge clk);
    #2;
    for (int i = 0; i < 10 && !imem_resp_valid; i++) begin @(posedge clk); #2; end
    vectors++;
    if (imem_resp_valid !== 1'b1) begin
      miscompares++; $display("FAIL redir_resp_setup: got resp_valid=%b expected 1", imem_resp_valid);
    end
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_resp_no_deq: got inst_valid=%b expected 0", inst_valid);
    end
    @(posedge clk); #2; redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (occupancy !== CW'(0)) begin
      miscompares++; $display("FAIL redir_resp_flush: got occ=%0d expected 0", occupancy);
    end
    for (int i = 0; i < 30 && !found; i++) begin
      if (i > 0) @(negedge clk);
      if (inst_valid) found = 1;
    end
    vectors++;
    if (!found || inst_pc !== 32'h300 || inst !== mem_word(32'h300)) begin
      miscompares++;
      $display("FAIL redir_resp_first: got found=%b pc=%h inst=%h expected 1/00000300/%h",
               found, inst_pc, inst, mem_word(32'h300));
    end
  endtask

  task automatic test_misaligned();
    lat_min = 1; lat_max = 1; ready_pct = 0;
    do_reset(1'b1);
    @(posedge clk); #2;
    redirect = 1'b1; redirect_pc = 32'h203;
    @(posedge clk); #2; redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL misaligned: got valid=%b addr=%h expected 1/00000200", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_bypass_latency();
    bit found;
    found = 0;
    lat_min = 3; lat_max = 3; ready_pct = 100;
    do_reset(1'b1);
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_resp_valid) found = 1;
    end
    vectors++;
    if (!found || inst_valid !== BYP || (BYP && inst_pc !== 32'h0)) begin
      miscompares++;
      $display("FAIL latency_t: got found=%b inst_valid=%b pc=%h expected 1/%b/00000000",
               found, inst_valid, inst_pc, BYP);
    end
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== (BYP ? 32'h4 : 32'h0)) begin
      miscompares++;
      $display("FAIL latency_t1: got inst_valid=%b pc=%h expected 1/%h",
               inst_valid, inst_pc, BYP ? 32'h4 : 32'h0);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_req;
    out_t m_out[$];
    ent_t m_fifo[$];
    out_t r;
    ent_t e;
    bit exp_rv, keep, byp, exp_iv, consumed;
    lat_min = 1; lat_max = 4; ready_pct = 70;
    do_reset(1'b0);
    exp_req = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      redirect    = ($urandom_range(99) < 4);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      inst_ready  = ($urandom_range(99) < 60);
      @(negedge clk);
      vectors++;
      if (int'(occupancy) != m_fifo.size()) begin
        miscompares++; $display("FAIL rnd_occupancy: got %0d expected %0d", occupancy, m_fifo.size());
      end
      exp_rv = !redirect && (m_out.size() + m_fifo.size() < DEPTH);
      vectors++;
      if (imem_req_valid !== exp_rv) begin
        miscompares++; $display("FAIL rnd_req_valid: got %b expected %b", imem_req_valid, exp_rv);
      end
      if (imem_resp_valid && m_out.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rnd_spurious_resp: got response expected none outstanding");
      end
      keep   = imem_resp_valid && !redirect && m_out.size() > 0 && !m_out[0].stale;
      byp    = BYP && keep && m_fifo.size() == 0;
      exp_iv = !redirect && (m_fifo.size() > 0 || byp);
      vectors++;
      if (inst_valid !== exp_iv) begin
        miscompares++; $display("FAIL rnd_inst_valid: got %b expected %b", inst_valid, exp_iv);
      end else if (exp_iv) begin
        e = byp ? '{mem_word(m_out[0].addr), m_out[0].addr} : m_fifo[0];
        vectors++;
        if (inst !== e.inst || inst_pc !== e.pc) begin
          miscompares++;
          $display("FAIL rnd_inst: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, e.pc, e.inst);
        end
      end
      consumed = exp_iv && inst_ready;
      r = '{32'h0, 1'b1};
      if (imem_resp_valid && m_out.size() > 0) r = m_out.pop_front();
      if (consumed && !byp && m_fifo.size() > 0) m_fifo.delete(0);
      if (keep && !(byp && consumed)) m_fifo.push_back('{mem_word(r.addr), r.addr});
      if (exp_rv && imem_req_valid && imem_req_ready) begin
        vectors++;
        if (imem_req_addr !== exp_req) begin
          miscompares++; $display("FAIL rnd_req_addr: got %h expected %h", imem_req_addr, exp_req);
        end
        m_out.push_back('{exp_req, 1'b0});
        exp_req += 4;
      end
      if (redirect) begin
        foreach (m_out[k]) m_out[k].stale = 1'b1;
        m_fifo.delete();
        exp_req = {redirect_pc[31:2], 2'b00};
      end
      @(posedge clk); #2;
    end
    redirect = 1'b0; inst_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    ready_pct = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_with_resp();
    test_misaligned();
    test_bypass_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
